boreal_sram_dma_engine: RTL and testbench

- Single-channel DMA engine that drives the DMA port of one 4 KB SRAM tile (DEPTH x 32-bit words).
- Moves a block of words between the tile and a 32-bit valid/ready stream.
  - Direction 0 (MEM2STR): reads tile words and emits them on the master stream.
  - Direction 1 (STR2MEM): accepts words from the slave stream and writes them into the tile.
- Sits directly upstream of the tile's DMA port. The tile gives the CPU bus port priority, so this engine must tolerate arbitrary ack stalls.

---
 rtl/boreal_sram_dma_engine_pkg.sv | 23 ++
 rtl/boreal_sram_dma_engine_if.sv | 31 +++
 rtl/boreal_sram_dma_engine_addr_gen.sv | 36 +++
 rtl/boreal_sram_dma_engine.sv | 188 ++++++++++++++++++
 tb/tb_boreal_sram_dma_engine.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/boreal_sram_dma_engine_pkg.sv
// boreal_dma_pkg: shared definitions for the boreal SRAM tile DMA engine.
// Holds the FSM state encoding, transfer-direction constants and the
// default ack-starvation limit used when BOREAL_DMA_TIMEOUT_EN is defined.
package boreal_dma_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEM_REQ = 2'd1;
    localparam logic [1:0] ST_STREAM  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_MEM_REQ = ST_MEM_REQ,
        S_STREAM  = ST_STREAM,
        S_DONE    = ST_DONE
    } dma_state_e;

    localparam logic DIR_MEM2STR = 1'b0;
    localparam logic DIR_STR2MEM = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/boreal_sram_dma_engine_if.sv
// Bus bundle between the DMA engine and its surroundings: the read-data
// stream (m_*), the write-data stream (s_*) and the SRAM tile DMA port.
// The master modport is the engine's view, slave is the environment's.
interface boreal_sram_dma_engine_if #(
    parameter int DEPTH_LOG = 10
);
    logic                 m_valid;
    logic                 m_ready;
    logic [31:0]          m_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [31:0]          s_data;
    logic                 dma_sel;
    logic                 dma_wr;
    logic [DEPTH_LOG-1:0] dma_addr;
    logic [31:0]          dma_wdata;
    logic [31:0]          dma_rdata;
    logic                 dma_ack;

    modport master (
        output m_valid, m_data, s_ready,
        output dma_sel, dma_wr, dma_addr, dma_wdata,
        input  m_ready, s_valid, s_data, dma_rdata, dma_ack
    );

    modport slave (
        input  m_valid, m_data, s_ready,
        input  dma_sel, dma_wr, dma_addr, dma_wdata,
        output m_ready, s_valid, s_data, dma_rdata, dma_ack
    );
endinterface

// File: rtl/boreal_sram_dma_engine_addr_gen.sv
// boreal_dma_addr_gen: word address / remaining-count register pair.
// The address wraps from DEPTH-1 back to 0; last flags the final word.
module boreal_dma_addr_gen #(
    parameter int DEPTH     = 1024,
    parameter int DEPTH_LOG = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [DEPTH_LOG-1:0] base,
    input  logic [DEPTH_LOG:0]   len,
    output logic [DEPTH_LOG-1:0] cur_addr,
    output logic [DEPTH_LOG:0]   remaining,
    output logic                 last
);
    localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);
    localparam logic [DEPTH_LOG:0]   ONE_WORD  = (DEPTH_LOG + 1)'(1);

    // Load the transfer window at start, then advance one word per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (load) begin
            cur_addr  <= base;
            remaining <= len;
        end else if (step) begin
            cur_addr  <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
            remaining <= remaining - ONE_WORD;
        end
    end

    assign last = (remaining == ONE_WORD);

endmodule

// File: rtl/boreal_sram_dma_engine.sv
// boreal_sram_dma_engine: single-channel DMA between one SRAM tile's DMA
// port and a 32-bit valid/ready stream (MEM2STR reads, STR2MEM writes).
// Optional macro BOREAL_DMA_TIMEOUT_EN adds an ack-starvation timeout that
// sets the sticky err flag; without it err is 0 and requests wait forever.
module boreal_sram_dma_engine
    import boreal_dma_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int DEPTH_LOG      = 10,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      dir,
    input  logic [DEPTH_LOG-1:0]      base_addr,
    input  logic [DEPTH_LOG:0]        len,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    boreal_sram_dma_engine_if.master  bus
);
    dma_state_e           state_q, state_d;
    logic                 dir_q;
    logic                 req_q, req_d;
    logic                 abort_q;
    logic                 abort_eff;
    logic [31:0]          rbuf, wbuf;
    logic                 load, step, rbuf_en, wbuf_en, err_set;
    logic [DEPTH_LOG-1:0] cur_addr;
    logic [DEPTH_LOG:0]   remaining;
    logic                 last;

    boreal_dma_addr_gen #(
        .DEPTH     (DEPTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .base      (base_addr),
        .len       (len),
        .cur_addr  (cur_addr),
        .remaining (remaining),
        .last      (last)
    );

    // An abort pulse is remembered until the next word boundary is reached
    assign abort_eff = abort | abort_q;

`ifdef BOREAL_DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt;
    logic          err_q;

    // Count request cycles without an ack; restarts on every ack or new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state_q != S_MEM_REQ || bus.dma_ack) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state and datapath enables; every transition sits on a word boundary
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        load    = 1'b0;
        step    = 1'b0;
        rbuf_en = 1'b0;
        wbuf_en = 1'b0;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (dir == DIR_MEM2STR) begin
                        state_d = S_MEM_REQ;
                        req_d   = 1'b1;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_MEM_REQ: begin
                if (bus.dma_ack) begin
                    req_d = 1'b0;
                    if (dir_q == DIR_MEM2STR) begin
                        rbuf_en = 1'b1;
                        state_d = S_STREAM;
                    end else begin
                        step    = 1'b1;
                        state_d = (last || abort_eff) ? S_DONE : S_STREAM;
                    end
                end
`ifdef BOREAL_DMA_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    req_d   = 1'b0;
                    err_set = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_STREAM: begin
                if (dir_q == DIR_MEM2STR) begin
                    if (bus.m_ready) begin
                        step = 1'b1;
                        if (last || abort_eff) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_MEM_REQ;
                            req_d   = 1'b1;
                        end
                    end
                end else if (bus.s_valid) begin
                    wbuf_en = 1'b1;
                    state_d = S_MEM_REQ;
                    req_d   = 1'b1;
                end else if (abort_eff) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, request flag, captured direction and the data buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            dir_q   <= 1'b0;
            abort_q <= 1'b0;
            rbuf    <= '0;
            wbuf    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            if (load) dir_q <= dir;
            if (state_q == S_IDLE) abort_q <= 1'b0;
            else if (abort)        abort_q <= 1'b1;
            if (rbuf_en) rbuf <= bus.dma_rdata;
            if (wbuf_en) wbuf <= bus.s_data;
        end
    end

    // The ack cycle masks dma_sel so the tile never sees a second access
    assign bus.dma_sel   = (state_q == S_MEM_REQ) & req_q & ~bus.dma_ack;
    assign bus.dma_wr    = (state_q == S_MEM_REQ) & dir_q;
    assign bus.dma_addr  = cur_addr;
    assign bus.dma_wdata = wbuf;
    assign bus.m_valid   = (state_q == S_STREAM) & (dir_q == DIR_MEM2STR);
    assign bus.m_data    = rbuf;
    assign bus.s_ready   = (state_q == S_STREAM) & (dir_q == DIR_STR2MEM);
    assign busy          = (state_q == S_MEM_REQ) | (state_q == S_STREAM);
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_boreal_sram_dma_engine.sv
// tb_boreal_sram_dma_engine: directed bench for the SRAM tile DMA engine.
// Expected stream words go into a queue checked by a negedge monitor; a
// behavioural tile model answers DMA requests one cycle after acceptance.
// Define BOREAL_DMA_TIMEOUT_EN to also exercise the ack-starvation timeout.
module tb_boreal_sram_dma_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        dir;
    logic [9:0]  base_addr;
    logic [10:0] len;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic        bus_busy;

    boreal_sram_dma_engine_if #(.DEPTH_LOG(10)) bus ();

    boreal_sram_dma_engine #(
        .DEPTH          (1024),
        .DEPTH_LOG      (10),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dir       (dir),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus.master)
    );

    logic [31:0] mem [0:1023];
    logic [31:0] exp_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    int cycle        = 0;
    int accept_count = 0;
    int hs_count     = 0;
    int done_count   = 0;
    int sel_count    = 0;
    int last_hs      = 0;
    int done_cycle   = 0;
    int start_cycle  = 0;
    logic        prev_done   = 1'b0;
    logic        prev_mvalid = 1'b0;
    logic        prev_mready = 1'b0;
    logic [31:0] prev_mdata  = '0;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tile model: accepts a request when the CPU port is idle, acks next cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dma_ack   <= 1'b0;
            bus.dma_rdata <= '0;
        end else begin
            bus.dma_ack <= 1'b0;
            if (bus.dma_sel && !bus_busy) begin
                accept_count++;
                if (bus.dma_wr) mem[bus.dma_addr] = bus.dma_wdata;
                else            bus.dma_rdata <= mem[bus.dma_addr];
                bus.dma_ack <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: stream scoreboard, done pulse width and m_valid stability
    always @(negedge clk) begin
        if (rst_n) begin
            cycle++;
            if (bus.dma_sel) sel_count++;
            if (prev_mvalid && !prev_mready) begin
                checkOutput("m_valid_held", {31'd0, bus.m_valid}, 32'd1);
                checkOutput("m_data_stable", bus.m_data, prev_mdata);
            end
            if (bus.m_valid && bus.m_ready) begin
                hs_count++;
                last_hs = cycle;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", bus.m_data, 32'hDEAD_BEEF);
                end else begin
                    checkOutput("m_data", bus.m_data, exp_q.pop_front());
                end
            end
            if (done) begin
                done_count++;
                done_cycle = cycle;
                checkOutput("done_one_cycle", {31'd0, prev_done}, 32'd0);
            end
            prev_done   = done;
            prev_mvalid = bus.m_valid;
            prev_mready = bus.m_ready;
            prev_mdata  = bus.m_data;
        end
    end

    task automatic applyStimulus(input logic d, input logic [9:0] b, input logic [10:0] l);
        @(posedge clk); #1;
        start = 1'b1; dir = d; base_addr = b; len = l;
        start_cycle = cycle + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int prev, input int budget, input string name);
        int n = 0;
        while (done_count == prev && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_count == prev) checkOutput(name, 32'd0, 32'd1);
    endtask

    task automatic waitValid(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_valid && n < budget);
        if (!bus.m_valid) checkOutput(name, 32'd0, 32'd1);
    endtask

    task automatic sendWord(input logic [31:0] w);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_ready && n < 50);
        if (!bus.s_ready) checkOutput("s_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    initial begin
        int d0, a0, h0, s0;
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; base_addr = '0; len = '0;
        abort = 1'b0; bus_busy = 1'b0;
        bus.m_ready = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",    {31'd0, busy},        32'd0);
        checkOutput("rst_done",    {31'd0, done},        32'd0);
        checkOutput("rst_err",     {31'd0, err},         32'd0);
        checkOutput("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        checkOutput("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        checkOutput("rst_dma_sel", {31'd0, bus.dma_sel}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] MEM2STR base 0x010 len 4");
        for (int i = 0; i < 4; i++) begin
            mem[10'h010 + i] = 32'hA0 + i;
            exp_q.push_back(32'hA0 + i);
        end
        bus.m_ready = 1'b1;
        d0 = done_count; a0 = accept_count; h0 = hs_count;
        applyStimulus(1'b0, 10'h010, 11'd4);
        waitDone(d0, 100, "t1_done_timeout");
        checkOutput("t1_words",     32'(hs_count - h0),     32'd4);
        checkOutput("t1_acks",      32'(accept_count - a0), 32'd4);
        checkOutput("t1_done_lat",  32'(done_cycle - last_hs), 32'd1);

        $display("[TB] STR2MEM base 0x3FE len 3 with wrap");
        d0 = done_count;
        applyStimulus(1'b1, 10'h3FE, 11'd3);
        sendWord(32'h11);
        sendWord(32'h22);
        sendWord(32'h33);
        waitDone(d0, 50, "t2_done_timeout");
        @(negedge clk);
        checkOutput("t2_mem_3fe", mem[10'h3FE], 32'h11);
        checkOutput("t2_mem_3ff", mem[10'h3FF], 32'h22);
        checkOutput("t2_mem_000", mem[10'h000], 32'h33);
        checkOutput("t2_busy_after", {31'd0, busy}, 32'd0);

        $display("[TB] MEM2STR len 2 with CPU port stall");
        mem[10'h100] = 32'hB0; mem[10'h101] = 32'hB1;
        exp_q.push_back(32'hB0); exp_q.push_back(32'hB1);
        bus_busy = 1'b1;
        d0 = done_count; a0 = accept_count; s0 = 0;
        applyStimulus(1'b0, 10'h100, 11'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.dma_sel) s0++;
        end
        checkOutput("t3_sel_held",   32'(s0), 32'd10);
        checkOutput("t3_no_accept",  32'(accept_count - a0), 32'd0);
        @(posedge clk); #1;
        bus_busy = 1'b0;
        waitDone(d0, 50, "t3_done_timeout");
        checkOutput("t3_accepts", 32'(accept_count - a0), 32'd2);

        $display("[TB] len 0 start");
        s0 = sel_count; d0 = done_count;
        applyStimulus(1'b0, 10'h055, 11'd0);
        @(negedge clk);
        checkOutput("t4_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        checkOutput("t4_done_low", {31'd0, done}, 32'd0);
        checkOutput("t4_no_sel", 32'(sel_count - s0), 32'd0);

        $display("[TB] abort during word 2 of 8");
        for (int i = 0; i < 8; i++) mem[10'h200 + i] = 32'hC0 + i;
        exp_q.push_back(32'hC0); exp_q.push_back(32'hC1);
        bus.m_ready = 1'b0;
        d0 = done_count; h0 = hs_count;
        applyStimulus(1'b0, 10'h200, 11'd8);
        waitValid(50, "t5_word1_timeout");
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        waitValid(50, "t5_word2_timeout");
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t5_valid_kept", {31'd0, bus.m_valid}, 32'd1);
        checkOutput("t5_data_kept",  bus.m_data, 32'hC1);
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        waitDone(d0, 50, "t5_done_timeout");
        repeat (4) @(negedge clk);
        checkOutput("t5_words", 32'(hs_count - h0), 32'd2);

`ifdef BOREAL_DMA_TIMEOUT_EN
        $display("[TB] ack starvation timeout");
        bus_busy = 1'b1;
        d0 = done_count;
        applyStimulus(1'b0, 10'h000, 11'd1);
        waitDone(d0, 40, "t6_done_timeout");
        checkOutput("t6_err", {31'd0, err}, 32'd1);
        checkOutput("t6_done_window",
                    {31'd0, ((done_cycle - start_cycle) >= 16) && ((done_cycle - start_cycle) <= 18)}, 32'd1);
        @(posedge clk); #1;
        bus_busy = 1'b0;
        d0 = done_count;
        applyStimulus(1'b0, 10'h000, 11'd0);
        waitDone(d0, 10, "t6_clear_timeout");
        checkOutput("t6_err_cleared", {31'd0, err}, 32'd0);
`endif

        checkOutput("final_err", {31'd0, err}, 32'd0);
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
